// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM read-port arbiter.
// Holds port indices, the response bundle and the address check.
package rom_arb_pkg;

    localparam int ADDR_W_P = 32;
    localparam int DATA_W_P = 32;
    localparam int ROM_AW_P = 12;

    localparam int PORT_FETCH = 0;
    localparam int PORT_LOAD  = 1;

    typedef struct packed {
        logic                valid;
        logic                err;
        logic [DATA_W_P-1:0] data;
    } resp_t;

    // Flags a misaligned word address or one past the last ROM word.
    // Anything above 2^aw-4 is out of range, which also catches any
    // nonzero high address bits.
    function automatic logic addr_err(input logic [63:0] addr,
                                      input int          aw);
        logic [63:0] lim;
        lim = (64'd1 << aw) - 64'd4;
        return (addr[1:0] != 2'b00) || (addr > lim);
    endfunction

endpackage

// File: rtl/rom_arb_resp_buf.sv
// One-deep registered response buffer (EMPTY/FULL) for one port.
// Ports: clk_i/rst_i, load_i+data_i+err_i capture a response,
//   resp_ready_i drains it, resp_o holds it, can_accept_o means a
//   load this cycle is safe (empty, or draining now).
module rom_arb_resp_buf
    import rom_arb_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [DATA_W_P-1:0] data_i,
    input  logic                err_i,
    input  logic                resp_ready_i,
    output resp_t               resp_o,
    output logic                can_accept_o
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic                err_q, err_d;
    logic [DATA_W_P-1:0] data_q, data_d;
    logic                drain;

    always_comb begin
        drain        = (state_q == FULL) && resp_ready_i;
        can_accept_o = (state_q == EMPTY) || drain;
        state_d      = state_q;
        err_d        = err_q;
        data_d       = data_q;
        case (state_q)
            EMPTY: if (load_i) state_d = FULL;
            FULL:  if (drain && !load_i) state_d = EMPTY;
        endcase
        if (load_i) begin
            err_d  = err_i;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign resp_o.valid = (state_q == FULL);
    assign resp_o.err   = err_q;
    assign resp_o.data  = data_q;

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing the instruction ROM read port between
// fetch (port 0) and constant loads (port 1).
// Ports: req_valid_i/req_addr*_i/req_ready_o request handshake,
//   resp_valid_o/resp_data*_o/resp_err_o/resp_ready_i response
//   handshake, rom_addr_o/rom_data_i combinational ROM port.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_P,
    parameter int DATA_W = DATA_W_P,
    parameter int ROM_AW = ROM_AW_P
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_valid_i,
    input  logic [ADDR_W-1:0] req_addr0_i,
    input  logic [ADDR_W-1:0] req_addr1_i,
    output logic [1:0]        req_ready_o,
    output logic [1:0]        resp_valid_o,
    output logic [DATA_W-1:0] resp_data0_o,
    output logic [DATA_W-1:0] resp_data1_o,
    output logic [1:0]        resp_err_o,
    input  logic [1:0]        resp_ready_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i
);

    logic              lp_q, lp_d;
    logic [1:0]        can_acc;
    logic [1:0]        elig;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] gnt_addr;
    logic              gnt_err;
    logic [DATA_W-1:0] gnt_data;
    resp_t             rsp0, rsp1;

    always_comb begin
        // No acceptance while reset holds the buffers.
        elig = req_valid_i & can_acc & {2{~rst_i}};
        case (elig)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = lp_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase

        lp_d = lp_q;
        if (gnt[PORT_LOAD])
            lp_d = 1'b1;
        else if (gnt[PORT_FETCH])
            lp_d = 1'b0;

        unique case (1'b1)
            gnt[PORT_FETCH]: gnt_addr = req_addr0_i;
            gnt[PORT_LOAD]:  gnt_addr = req_addr1_i;
            default:         gnt_addr = '0;
        endcase

        gnt_err  = addr_err(64'(gnt_addr), ROM_AW);
        gnt_data = gnt_err ? '0 : rom_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            lp_q <= 1'b1;
        else
            lp_q <= lp_d;
    end

    rom_arb_resp_buf u_buf0 (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (gnt[PORT_FETCH]),
        .data_i       (gnt_data),
        .err_i        (gnt_err),
        .resp_ready_i (resp_ready_i[PORT_FETCH]),
        .resp_o       (rsp0),
        .can_accept_o (can_acc[PORT_FETCH])
    );

    rom_arb_resp_buf u_buf1 (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (gnt[PORT_LOAD]),
        .data_i       (gnt_data),
        .err_i        (gnt_err),
        .resp_ready_i (resp_ready_i[PORT_LOAD]),
        .resp_o       (rsp1),
        .can_accept_o (can_acc[PORT_LOAD])
    );

    assign req_ready_o  = gnt;
    assign rom_addr_o   = gnt_addr;
    assign resp_valid_o = {rsp1.valid, rsp0.valid};
    assign resp_err_o   = {rsp1.err, rsp0.err};
    assign resp_data0_o = rsp0.data;
    assign resp_data1_o = rsp1.data;

endmodule
